// File: rtl/wb_master.sv
// Wishbone classic single-transfer master: one valid/ready command in, one
// bus cycle out, one-cycle response pulse back with read data and error flag.
module wb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    CYC_O,
  output logic                    STB_O,
  output logic                    WE_O,
  output logic [ADDR_WIDTH-1:0]   ADR_O,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  output logic [DATA_WIDTH/8-1:0] SEL_O,
  input  logic                    ACK_I,
  input  logic                    ERR_I,
  input  logic [DATA_WIDTH-1:0]   DAT_I
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e                state_q;
  logic                  cyc_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SW-1:0]         sel_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic [CW-1:0]         cnt_q;
  logic                  timeout_hit;

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Ready is gated by reset directly so it reads 0 while reset is held and
  // 1 in the very first cycle after release.
  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign CYC_O      = cyc_q;
  assign STB_O      = cyc_q;
  assign WE_O       = we_q;
  assign ADR_O      = adr_q;
  assign DAT_O      = dat_q;
  assign SEL_O      = sel_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            adr_q   <= req_addr;
            dat_q   <= req_wdata;
            sel_q   <= req_sel;
            cnt_q   <= '0;
            cyc_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          // Priority: ERR_I over ACK_I over timeout.
          if (ERR_I) begin
            cyc_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= RESP;
          end else if (ACK_I) begin
            cyc_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? '0 : DAT_I;
            state_q      <= RESP;
          end else if (timeout_hit) begin
            cyc_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master.sv
// Scoreboard bench for wb_master: driver pushes expected responses, a
// negedge monitor checks bus signals and pops on every resp_valid pulse.
module tb_wb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_sel;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          CYC_O, STB_O, WE_O;
  logic [AW-1:0] ADR_O;
  logic [DW-1:0] DAT_O;
  logic [3:0]    SEL_O;
  logic          ACK_I, ERR_I;
  logic [DW-1:0] DAT_I;

  wb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
    .DAT_O(DAT_O), .SEL_O(SEL_O), .ACK_I(ACK_I), .ERR_I(ERR_I), .DAT_I(DAT_I)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          nstb;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_sel;

  int          ack_at = 1;
  int          err_at = 0;
  logic        echo = 1'b0;
  logic [31:0] rd_data = '0;
  int          stb_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: terminates on a configurable BUS cycle number.
  initial begin
    ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = '0;
    forever begin
      @(negedge clock);
      if (STB_O) begin
        stb_cnt++;
        ACK_I = (ack_at != 0) && (stb_cnt == ack_at);
        ERR_I = (err_at != 0) && (stb_cnt == err_at);
        DAT_I = echo ? (ADR_O + 32'h1000_0000) : rd_data;
      end else begin
        stb_cnt = 0;
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        DAT_I = 32'hBAD0_BAD0;
      end
    end
  end

  int stb_len = 0;
  bit after_resp = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        stb_len = 0;
        after_resp = 1'b0;
      end else begin
        if (after_resp) begin
          chk("post_resp_valid_ready", {resp_valid, req_ready}, 2'b01);
          after_resp = 1'b0;
        end
        if (STB_O) begin
          stb_len++;
          chk("bus_fields", {CYC_O, WE_O, ADR_O, DAT_O, SEL_O},
              {1'b1, cur_we, cur_addr, cur_wdata, cur_sel});
        end
        if (resp_valid) begin
          if (sb.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
          end else begin
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", resp_err, e.err);
            chk("stb_cycles", stb_len, e.nstb);
            chk("resp_bus_idle", {req_ready, CYC_O, STB_O}, 3'b000);
          end
          stb_len = 0;
          after_resp = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [31:0] er, input logic ee,
                      input int ns, input bit push, output time t_acc);
    int w;
    exp_t e;
    w = 0;
    req_we = we; req_addr = a; req_wdata = wd; req_sel = s; req_valid = 1'b1;
    while (!req_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    t_acc = 0;
    if (!req_ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end else begin
      @(posedge clock);
      t_acc = $time;
      cur_we = we; cur_addr = a; cur_wdata = wd; cur_sel = s;
      if (push) begin
        e.rdata = er; e.err = ee; e.nstb = ns;
        sb.push_back(e);
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || STB_O) && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= 200) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1, t2, t3;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
    repeat (3) @(negedge clock);
    chk("reset_outputs",
        {CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, resp_valid, resp_rdata, resp_err, req_ready},
        '0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", req_ready, 1'b1);

    // Write, zero-wait.
    ack_at = 1; err_at = 0; rd_data = 32'hAAAA_5555;
    send(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1, 1'b1, t0);
    req_valid = 1'b0;
    wait_idle();

    // Read, three wait states.
    ack_at = 4; rd_data = 32'h1234_5678;
    send(1'b0, 32'h204, 32'h0BAD_F00D, 4'h3, 32'h1234_5678, 1'b0, 4, 1'b1, t0);
    req_valid = 1'b0;
    wait_idle();

    // Timeout, then ACK on the last allowed cycle.
    ack_at = 0; rd_data = 32'h5555_5555;
    send(1'b0, 32'h308, 32'h0, 4'hF, 32'h0, 1'b1, 16, 1'b1, t0);
    req_valid = 1'b0;
    wait_idle();
    ack_at = 16; rd_data = 32'hCAFE_F00D;
    send(1'b0, 32'h30C, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 16, 1'b1, t0);
    req_valid = 1'b0;
    wait_idle();

    // ERR_I together with ACK_I on a read, then ERR_I alone on a write.
    ack_at = 2; err_at = 2; rd_data = 32'hFFFF_FFFF;
    send(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 2, 1'b1, t0);
    req_valid = 1'b0;
    wait_idle();
    ack_at = 0; err_at = 1;
    send(1'b1, 32'h404, 32'h7777_8888, 4'h5, 32'h0, 1'b1, 1, 1'b1, t0);
    req_valid = 1'b0;
    wait_idle();
    err_at = 0;

    // Back-to-back, req_valid held, zero-wait echo slave.
    ack_at = 1; echo = 1'b1;
    send(1'b1, 32'h500, 32'h1111_1111, 4'hF, 32'h0,         1'b0, 1, 1'b1, t0);
    send(1'b0, 32'h504, 32'h2222_2222, 4'hF, 32'h1000_0504, 1'b0, 1, 1'b1, t1);
    send(1'b0, 32'h508, 32'h3333_3333, 4'h1, 32'h1000_0508, 1'b0, 1, 1'b1, t2);
    send(1'b1, 32'h50C, 32'h4444_4444, 4'hC, 32'h0,         1'b0, 1, 1'b1, t3);
    req_valid = 1'b0;
    chk("b2b_spacing_1", t1 - t0, 64'd30);
    chk("b2b_spacing_2", t2 - t1, 64'd30);
    chk("b2b_spacing_3", t3 - t2, 64'd30);
    wait_idle();
    echo = 1'b0;

    // Reset during the second BUS cycle drops the request.
    ack_at = 0; rd_data = 32'h9999_9999;
    send(1'b0, 32'h600, 32'h6666_6666, 4'hF, 32'h0, 1'b0, 0, 1'b0, t0);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("mid_bus_reset_outputs",
        {CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, resp_valid, resp_rdata, resp_err, req_ready},
        '0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_mid_reset", {req_ready, resp_valid, STB_O}, 3'b100);
    ack_at = 1; rd_data = 32'h0F0F_0F0F;
    send(1'b0, 32'h604, 32'h0, 4'hF, 32'h0F0F_0F0F, 1'b0, 1, 1'b1, t0);
    req_valid = 1'b0;
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
